// File: rtl/gfx_pkg.sv
// Shared VGA 640x480 timing constants, coordinate/colour widths and scanout
// types for the graphics block.
package gfx_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W   = 10;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 4;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [X_W-1:0]     x_t;
  typedef logic [Y_W-1:0]     y_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} scan_state_e;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } tflags_t;
endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer read port: scanout drives address/strobe/buffer select,
// memory returns data a fixed latency later.
interface fb_scanout_if;
  import gfx_pkg::*;
  logic   fb_re;
  x_t     fb_rd_x;
  y_t     fb_rd_y;
  logic   fb_rd_buf;
  color_t fb_rd_data;

  modport master (output fb_re, fb_rd_x, fb_rd_y, fb_rd_buf, input fb_rd_data);
  modport slave  (input fb_re, fb_rd_x, fb_rd_y, fb_rd_buf, output fb_rd_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and the per-position timing flags.
// Standalone so raster-side benches can reuse the same timing.
module vga_timing_gen #(
  parameter int H_ACTIVE = gfx_pkg::H_ACTIVE,
  parameter int H_FP     = gfx_pkg::H_FP,
  parameter int H_SYNC   = gfx_pkg::H_SYNC,
  parameter int H_BP     = gfx_pkg::H_BP,
  parameter int V_ACTIVE = gfx_pkg::V_ACTIVE,
  parameter int V_FP     = gfx_pkg::V_FP,
  parameter int V_SYNC   = gfx_pkg::V_SYNC,
  parameter int V_BP     = gfx_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output gfx_pkg::cnt_t    h_cnt,
  output gfx_pkg::cnt_t    v_cnt,
  output gfx_pkg::tflags_t flags,
  output logic             last_fetch,
  output logic             frame_end
);
  import gfx_pkg::*;

  localparam cnt_t H_LAST = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  logic h_end, v_end;
  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (advance) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + cnt_t'(1);
      end else begin
        h_cnt <= h_cnt + cnt_t'(1);
      end
    end
  end

  always_comb begin
    flags.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    flags.hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    flags.vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    flags.fs     = (h_cnt == '0) && (v_cnt == '0);
  end

  assign last_fetch = (h_cnt == H_ACT - cnt_t'(1)) && (v_cnt == V_ACT - cnt_t'(1));
  assign frame_end  = h_end && v_end;
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: VGA timing, one read per pixel, latency-matched
// sync/blank/pixel outputs and frame-boundary double-buffer swap.
module fb_scanout #(
  parameter int   RD_LATENCY = 2,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   H_ACTIVE   = gfx_pkg::H_ACTIVE,
  parameter int   H_FP       = gfx_pkg::H_FP,
  parameter int   H_SYNC     = gfx_pkg::H_SYNC,
  parameter int   H_BP       = gfx_pkg::H_BP,
  parameter int   V_ACTIVE   = gfx_pkg::V_ACTIVE,
  parameter int   V_FP       = gfx_pkg::V_FP,
  parameter int   V_SYNC     = gfx_pkg::V_SYNC,
  parameter int   V_BP       = gfx_pkg::V_BP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            swap_req,
  output logic            swap_ack,
  fb_scanout_if.master    fb,
  output logic            hsync,
  output logic            vsync,
  output logic            blank,
  output gfx_pkg::color_t pixel,
  output logic            frame_start
);
  import gfx_pkg::*;

  scan_state_e state, state_nxt;
  cnt_t        h_cnt, v_cnt;
  tflags_t     flags, fetch_flags, out_flags;
  logic        last_fetch, frame_end, live, fetch_on, swap_hit;

  // Index 0 is the fetch stage; index RD_LATENCY lines up with fb_rd_data.
  tflags_t [RD_LATENCY:0] vld_pipe;

  assign live = (state != IDLE);

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tgen (
    .clk        (clk),
    .reset      (reset),
    .advance    (live),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .flags      (flags),
    .last_fetch (last_fetch),
    .frame_end  (frame_end)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Leaving RUN always finishes the current frame; a disable that lands on the
  // wrap cycle goes straight to IDLE rather than starting another frame.
  always_comb begin
    state_nxt = state;
    swap_hit  = 1'b0;
    case (state)
      IDLE: begin
        swap_hit = swap_req;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        swap_hit = swap_req && last_fetch;
        if (!enable) state_nxt = frame_end ? IDLE : DRAIN;
      end
      DRAIN: begin
        swap_hit = swap_req && last_fetch;
        if (enable)         state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_on    = live && flags.active;
  assign fetch_flags = live ? flags : tflags_t'('0);
  assign out_flags   = vld_pipe[RD_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      fb.fb_re   <= 1'b0;
      fb.fb_rd_x <= '0;
      fb.fb_rd_y <= '0;
      vld_pipe   <= '0;
    end else begin
      fb.fb_re   <= fetch_on;
      fb.fb_rd_x <= fetch_on ? x_t'(h_cnt) : '0;
      fb.fb_rd_y <= fetch_on ? y_t'(v_cnt) : '0;
      vld_pipe   <= {vld_pipe[RD_LATENCY-1:0], fetch_flags};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank       <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      pixel       <= '0;
      frame_start <= 1'b0;
    end else begin
      blank       <= ~out_flags.active;
      hsync       <= out_flags.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= out_flags.vs ? SYNC_POL : ~SYNC_POL;
      pixel       <= out_flags.active ? fb.fb_rd_data : '0;
      frame_start <= out_flags.fs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb.fb_rd_buf <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      fb.fb_rd_buf <= fb.fb_rd_buf ^ swap_hit;
      swap_ack     <= swap_hit;
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench: full-size VGA timing (two latency/polarity variants) plus a
// shrunken raster for frame-level swap, drain, re-enable and reset behaviour.
module tb_fb_scanout;
  import gfx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_a, en_a, swr_a, rst_c, en_c, swr_c;
  logic   ack_a, hs_a, vs_a, bl_a, fs_a;
  logic   ack_b, hs_b, vs_b, bl_b, fs_b;
  logic   ack_c, hs_c, vs_c, bl_c, fs_c;
  color_t px_a, px_b, px_c;

  fb_scanout_if bus_a();
  fb_scanout_if bus_b();
  fb_scanout_if bus_c();

  fb_scanout u_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .swap_req(swr_a), .swap_ack(ack_a),
    .fb(bus_a), .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .pixel(px_a), .frame_start(fs_a)
  );

  fb_scanout #(.RD_LATENCY(4), .SYNC_POL(1'b1)) u_b (
    .clk(clk), .reset(rst_a), .enable(en_a), .swap_req(swr_a), .swap_ack(ack_b),
    .fb(bus_b), .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .pixel(px_b), .frame_start(fs_b)
  );

  // 16 x 10 raster: active 8x6, hsync at h 10..12, vsync at lines 7..8.
  fb_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .swap_req(swr_c), .swap_ack(ack_c),
    .fb(bus_c), .hsync(hs_c), .vsync(vs_c), .blank(bl_c), .pixel(px_c), .frame_start(fs_c)
  );

  // Memory model: data = column[3:0], returned RD_LATENCY cycles after the read.
  color_t mem_a [2] = '{default: '0};
  color_t mem_b [4] = '{default: '0};
  color_t mem_c [2] = '{default: '0};
  always @(posedge clk) begin
    mem_a[0] <= bus_a.fb_rd_x[3:0];
    mem_a[1] <= mem_a[0];
    mem_b[0] <= bus_b.fb_rd_x[3:0];
    for (int i = 1; i < 4; i++) mem_b[i] <= mem_b[i-1];
    mem_c[0] <= bus_c.fb_rd_x[3:0];
    mem_c[1] <= mem_c[0];
  end
  assign bus_a.fb_rd_data = mem_a[1];
  assign bus_b.fb_rd_data = mem_b[3];
  assign bus_c.fb_rd_data = mem_c[1];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int   re_cnt = 0, re_idle = 0, fs_first = -1, fs_second = -1;
  int   hs_fall = -1, hs_len = 0, hs_falls = 0, vs_fall = -1, vs_len = 0;
  int   ack_cnt = 0, ack_at = -1, tog_cnt = 0;
  logic hs_done = 1'b0, vs_done = 1'b0, prev_hs = 1'b1, prev_buf = 1'b0;

  initial begin
    rst_a = 1'b1; en_a = 1'b1; swr_a = 1'b0;
    rst_c = 1'b1; en_c = 1'b0; swr_c = 1'b0;
    repeat (3) tick;
    chk("a_rst_blank", bl_a, 1);
    chk("a_rst_hsync", hs_a, 1);
    chk("a_rst_vsync", vs_a, 1);
    chk("a_rst_re",    bus_a.fb_re, 0);
    chk("a_rst_pixel", px_a, 0);
    chk("a_rst_fs",    fs_a, 0);
    chk("a_rst_buf",   bus_a.fb_rd_buf, 0);
    chk("b_rst_hsync", hs_b, 0);
    chk("b_rst_vsync", vs_b, 0);
    rst_a = 1'b0;

    // c counts edges after reset release; edge 0 is IDLE -> RUN.
    for (int c = 0; c <= 801; c++) begin
      tick;
      case (c)
        0:   chk("a_idle_re", bus_a.fb_re, 0);
        1: begin
          chk("a_first_re", bus_a.fb_re, 1);
          chk("a_first_x",  bus_a.fb_rd_x, 0);
          chk("a_first_y",  bus_a.fb_rd_y, 0);
          chk("b_first_re", bus_b.fb_re, 1);
        end
        3:   chk("a_fill_blank", bl_a, 1);
        4: begin
          chk("a_px00",   px_a, 0);
          chk("a_fs",     fs_a, 1);
          chk("a_blank0", bl_a, 0);
        end
        5: begin
          chk("a_fs_pulse", fs_a, 0);
          chk("b_fs_early", fs_b, 0);
        end
        6:   chk("b_fs", fs_b, 1);
        11:  chk("b_px5", px_b, 5);
        644: begin
          chk("a_hblank", bl_a, 1);
          chk("a_hblank_px", px_a, 0);
        end
        659: chk("a_hs_pre",   hs_a, 1);
        660: chk("a_hs_start", hs_a, 0);
        661: chk("b_hs_pre",   hs_b, 0);
        662: chk("b_hs_start", hs_b, 1);
        755: chk("a_hs_last",  hs_a, 0);
        756: chk("a_hs_end",   hs_a, 1);
        757: chk("b_hs_last",  hs_b, 1);
        758: chk("b_hs_end",   hs_b, 0);
        800: chk("a_hblank_re", bus_a.fb_re, 0);
        801: begin
          chk("a_line1_re", bus_a.fb_re, 1);
          chk("a_line1_x",  bus_a.fb_rd_x, 0);
          chk("a_line1_y",  bus_a.fb_rd_y, 1);
        end
        default: ;
      endcase
      if (c == 5 || c == 19 || c == 21 || c == 643)
        chk("a_line0_px", px_a, (c - 4) % 16);
    end

    // Small raster: IDLE swaps, then a run of frames.
    repeat (3) tick;
    rst_c = 1'b0;
    tick;
    swr_c = 1'b1; tick; swr_c = 1'b0;
    chk("c_idle_ack",  ack_c, 1);
    chk("c_idle_buf1", bus_c.fb_rd_buf, 1);
    tick;
    chk("c_idle_ack_clr", ack_c, 0);
    swr_c = 1'b1; tick; swr_c = 1'b0;
    chk("c_idle_buf0", bus_c.fb_rd_buf, 0);
    chk("c_idle_re",   bus_c.fb_re, 0);
    en_c = 1'b1;

    for (int c = 0; c <= 760; c++) begin
      tick;
      if (c >= 1 && c <= 160 && bus_c.fb_re) re_cnt++;
      if (c >= 641 && c <= 700 && bus_c.fb_re) re_idle++;
      if (fs_c) begin
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
      if (c >= 4 && c <= 163 && prev_hs && !hs_c) hs_falls++;
      prev_hs = hs_c;
      if (!hs_c && hs_fall < 0) hs_fall = c;
      if (hs_fall >= 0 && !hs_done) begin
        if (!hs_c) hs_len++; else hs_done = 1'b1;
      end
      if (!vs_c && vs_fall < 0) vs_fall = c;
      if (vs_fall >= 0 && !vs_done) begin
        if (!vs_c) vs_len++; else vs_done = 1'b1;
      end
      if (c < 755) begin
        if (ack_c) begin
          ack_cnt++;
          ack_at = c;
          chk("c_ack_x", bus_c.fb_rd_x, 7);
          chk("c_ack_y", bus_c.fb_rd_y, 5);
          swr_c = 1'b0;
        end
        if (bus_c.fb_rd_buf !== prev_buf) tog_cnt++;
        prev_buf = bus_c.fb_rd_buf;
      end

      case (c)
        548: begin
          chk("c_drain_re", bus_c.fb_re, 1);
          chk("c_drain_x",  bus_c.fb_rd_x, 3);
          chk("c_drain_y",  bus_c.fb_rd_y, 4);
        end
        551: begin
          chk("c_drain_px",    px_c, 3);
          chk("c_drain_blank", bl_c, 0);
        end
        600: chk("c_drain_vs", vs_c, 0);
        641: chk("c_stop_re", bus_c.fb_re, 0);
        644: chk("c_stop_fs", fs_c, 0);
        700: begin
          chk("c_idle_blank", bl_c, 1);
          chk("c_idle_hs",    hs_c, 1);
          chk("c_idle_vs",    vs_c, 1);
          chk("c_idle_re2",   bus_c.fb_re, 0);
        end
        701: chk("c_reen_wait", bus_c.fb_re, 0);
        702: begin
          chk("c_reen_re", bus_c.fb_re, 1);
          chk("c_reen_x",  bus_c.fb_rd_x, 0);
          chk("c_reen_y",  bus_c.fb_rd_y, 0);
        end
        705: chk("c_reen_fs", fs_c, 1);
        754: begin
          chk("c_pre_rst_buf", bus_c.fb_rd_buf, 1);
          chk("c_pre_rst_x",   bus_c.fb_rd_x, 4);
          chk("c_pre_rst_y",   bus_c.fb_rd_y, 3);
        end
        755: begin
          chk("c_rst_re",    bus_c.fb_re, 0);
          chk("c_rst_x",     bus_c.fb_rd_x, 0);
          chk("c_rst_y",     bus_c.fb_rd_y, 0);
          chk("c_rst_blank", bl_c, 1);
          chk("c_rst_hs",    hs_c, 1);
          chk("c_rst_vs",    vs_c, 1);
          chk("c_rst_px",    px_c, 0);
          chk("c_rst_fs",    fs_c, 0);
          chk("c_rst_ack",   ack_c, 0);
          chk("c_rst_buf",   bus_c.fb_rd_buf, 0);
        end
        757: begin
          chk("c_restart_re", bus_c.fb_re, 1);
          chk("c_restart_x",  bus_c.fb_rd_x, 0);
          chk("c_restart_y",  bus_c.fb_rd_y, 0);
        end
        760: begin
          chk("c_restart_fs",    fs_c, 1);
          chk("c_restart_px",    px_c, 0);
          chk("c_restart_blank", bl_c, 0);
        end
        default: ;
      endcase

      case (c)
        170: swr_c = 1'b1;
        515: en_c  = 1'b0;
        700: en_c  = 1'b1;
        754: rst_c = 1'b1;
        755: rst_c = 1'b0;
        default: ;
      endcase
    end

    chk("c_re_per_frame", re_cnt, 48);
    chk("c_fs_first",     fs_first, 4);
    chk("c_frame_period", fs_second - fs_first, 160);
    chk("c_hs_fall",      hs_fall, 14);
    chk("c_hs_len",       hs_len, 3);
    chk("c_hs_per_frame", hs_falls, 10);
    chk("c_vs_fall",      vs_fall, 116);
    chk("c_vs_len",       vs_len, 32);
    chk("c_ack_count",    ack_cnt, 1);
    chk("c_ack_cycle",    ack_at, 248);
    chk("c_buf_toggles",  tog_cnt, 1);
    chk("c_idle_re_cnt",  re_idle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
